// File: rtl/column_tracker_if.sv
// Pixel stream from the VGA timing / frame RAM read path into the column tracker.
interface column_tracker_if #(
  parameter int XW = 10,
  parameter int YW = 10
);
  logic          vs;
  logic          pix_en;
  logic          blank;
  logic          pix;
  logic [XW-1:0] DrawX;
  logic [YW-1:0] DrawY;

  modport master (output vs, pix_en, blank, pix, DrawX, DrawY);
  modport slave  (input  vs, pix_en, blank, pix, DrawX, DrawY);
endinterface

// File: rtl/column_tracker.sv
// Per-frame vertical centroid of lit pixels in CH sampled columns, one shared serial divider.
// Optional macro COLTRK_SMOOTH_EN adds first-order smoothing of accepted centres.
module column_tracker #(
  parameter int CH      = 2,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int SUMW    = 19,
  parameter int CNTW    = 10,
  parameter int V_RES   = 480,
  parameter int HALF_S  = 40,
`ifdef COLTRK_SMOOTH_EN
  parameter int SMOOTH_SH = 2,
`endif
  parameter int MIN_PIX = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  column_tracker_if.slave      vid,
  input  logic [CH*XW-1:0]     col_x,
  output logic [CH*YW-1:0]     center,
  output logic                 center_valid,
  output logic                 overrun
);

  localparam int CIW = (CH > 1) ? $clog2(CH) : 1;
  localparam int BW  = $clog2(SUMW);

  typedef enum logic [1:0] {ACCUM, DIVIDE, UPDATE} state_t;

  state_t          state;
  logic            vs_q;
  logic            frame_end;
  logic [CH-1:0]   hit;
  logic [SUMW-1:0] sum      [CH];
  logic [SUMW-1:0] sum_inc  [CH];
  logic [SUMW:0]   sum_add  [CH];
  logic [CNTW-1:0] cnt      [CH];
  logic [CNTW-1:0] cnt_inc  [CH];
  logic [SUMW-1:0] snap_sum [CH];
  logic [CNTW-1:0] snap_cnt [CH];
  logic [SUMW-1:0] q_res    [CH];
  logic [YW-1:0]   q_clamp  [CH];
  logic [YW-1:0]   new_ctr  [CH];
  logic [YW-1:0]   ctr      [CH];
`ifdef COLTRK_SMOOTH_EN
  logic signed [YW:0] diff  [CH];
`endif

  logic [SUMW-1:0] quo;
  logic [SUMW-1:0] quo_next;
  logic [CNTW-1:0] rem;
  logic [CNTW-1:0] rem_next;
  logic [CNTW:0]   rem_sh;
  logic [CNTW-1:0] rem_sub;
  logic            take;
  logic [BW-1:0]   bit_cnt;
  logic [CIW-1:0]  ch_idx;

  assign frame_end = vs_q & ~vid.vs;

  // Hit detection and saturating increments for every channel.
  always_comb begin
    for (int k = 0; k < CH; k++) begin
      hit[k]     = vid.pix_en & vid.blank & vid.pix & (vid.DrawX == col_x[k*XW +: XW]);
      sum_add[k] = {1'b0, sum[k]} + (SUMW+1)'(vid.DrawY);
      sum_inc[k] = sum_add[k][SUMW] ? '1 : sum_add[k][SUMW-1:0];
      cnt_inc[k] = (&cnt[k]) ? cnt[k] : cnt[k] + 1'b1;
    end
  end

  // One restoring-division step: remainder never exceeds the divisor, so CNTW bits suffice.
  always_comb begin
    rem_sh   = {rem, quo[SUMW-1]};
    take     = rem_sh >= {1'b0, snap_cnt[ch_idx]};
    rem_sub  = rem_sh[CNTW-1:0] - snap_cnt[ch_idx];
    rem_next = take ? rem_sub : rem_sh[CNTW-1:0];
    quo_next = {quo[SUMW-2:0], take};
  end

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      if (q_res[k] < SUMW'(HALF_S))
        q_clamp[k] = YW'(HALF_S);
      else if (q_res[k] > SUMW'(V_RES - 1 - HALF_S))
        q_clamp[k] = YW'(V_RES - 1 - HALF_S);
      else
        q_clamp[k] = q_res[k][YW-1:0];
`ifdef COLTRK_SMOOTH_EN
      diff[k]    = $signed({1'b0, q_clamp[k]}) - $signed({1'b0, ctr[k]});
      new_ctr[k] = ctr[k] + YW'(diff[k] >>> SMOOTH_SH);
`else
      new_ctr[k] = q_clamp[k];
`endif
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ACCUM;
      vs_q         <= 1'b0;
      center_valid <= 1'b0;
      overrun      <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      bit_cnt      <= '0;
      ch_idx       <= '0;
      for (int k = 0; k < CH; k++) begin
        sum[k]      <= '0;
        cnt[k]      <= '0;
        snap_sum[k] <= '0;
        snap_cnt[k] <= '0;
        q_res[k]    <= '0;
        ctr[k]      <= YW'(V_RES / 2);
      end
    end else begin
      vs_q         <= vid.vs;
      center_valid <= 1'b0;
      // A hit on the frame-end cycle already belongs to the next frame.
      for (int k = 0; k < CH; k++) begin
        if (frame_end) begin
          sum[k] <= hit[k] ? SUMW'(vid.DrawY) : '0;
          cnt[k] <= hit[k] ? CNTW'(1) : '0;
        end else if (hit[k]) begin
          sum[k] <= sum_inc[k];
          cnt[k] <= cnt_inc[k];
        end
      end
      if (frame_end && state != ACCUM)
        overrun <= 1'b1;
      case (state)
        ACCUM: begin
          if (frame_end) begin
            for (int k = 0; k < CH; k++) begin
              snap_sum[k] <= sum[k];
              snap_cnt[k] <= cnt[k];
            end
            quo     <= sum[0];
            rem     <= '0;
            bit_cnt <= '0;
            ch_idx  <= '0;
            state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          quo <= quo_next;
          rem <= rem_next;
          if (bit_cnt == BW'(SUMW - 1)) begin
            q_res[ch_idx] <= quo_next;
            bit_cnt       <= '0;
            rem           <= '0;
            if (ch_idx == CIW'(CH - 1)) begin
              state <= UPDATE;
            end else begin
              ch_idx <= ch_idx + 1'b1;
              quo    <= snap_sum[ch_idx + 1'b1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        UPDATE: begin
          for (int k = 0; k < CH; k++)
            if (snap_cnt[k] >= CNTW'(MIN_PIX))
              ctr[k] <= new_ctr[k];
          center_valid <= 1'b1;
          state        <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_out
    assign center[k*YW +: YW] = ctr[k];
  end

endmodule
